two_port_ram_be: RTL and testbench

//  Parametrised simple dual-port LUT RAM: one write port with byte enables, one read port.

---
 rtl/two_port_ram_be.sv | 119 +++++++++++
 tb/tb_two_port_ram_be.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/two_port_ram_be.sv
// two_port_ram_be: simple dual-port LUT RAM with one byte-enabled write
// port and one read port. A built-in clear engine sweeps every word to
// CLR_VALUE after reset and whenever clr is pulsed; writes are ignored and
// reads return zero while the sweep runs.
// Build option RAM_RD_REG_EN: when defined, r_data is registered (one cycle
// of read latency); when undefined, r_data is combinational from r_add.
module two_port_ram_be #(
   parameter  int                 A_WIDTH   = 4,
   parameter  int                 D_WIDTH   = 32,
   localparam int                 BE_WIDTH  = D_WIDTH / 8,
   parameter  logic [D_WIDTH-1:0] CLR_VALUE = '0,
   parameter  int                 BYPASS    = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                we,
   input  logic [BE_WIDTH-1:0] w_be,
   input  logic [A_WIDTH-1:0]  w_add,
   input  logic [D_WIDTH-1:0]  w_data,
   input  logic [A_WIDTH-1:0]  r_add,
   output logic [D_WIDTH-1:0]  r_data,
   output logic                busy
);

   localparam int DEPTH = 1 << A_WIDTH;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t               state;
   logic [A_WIDTH-1:0]   clr_cnt;
   logic [D_WIDTH-1:0]   mem [DEPTH];
   logic                 wr_ok;
   logic                 bypass_hit;
   logic [D_WIDTH-1:0]   rd_word;
   logic [D_WIDTH-1:0]   rd_value;

   // busy is taken straight from the state register, so it never glitches
   assign busy       = (state == CLEAR);
   assign wr_ok      = (state == READY) && !clr && we;
   assign bypass_hit = (BYPASS != 0) && wr_ok && (r_add == w_add);

   // Clear-engine FSM: sweep clr_cnt over every address, then sit in READY
   // until another clear request; a request mid-sweep restarts from zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         case (state)
            CLEAR: begin
               if (clr) begin
                  clr_cnt <= '0;
               end else if (clr_cnt == A_WIDTH'(DEPTH - 1)) begin
                  state   <= READY;
               end else begin
                  clr_cnt <= clr_cnt + A_WIDTH'(1);
               end
            end
            READY: begin
               if (clr) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
               end
            end
            default: begin
               state   <= CLEAR;
               clr_cnt <= '0;
            end
         endcase
      end
   end

   // Storage update: the sweep owns the array while clearing, otherwise
   // accepted writes update only the enabled byte lanes
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_cnt] <= CLR_VALUE;
      end else if (wr_ok) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (w_be[i]) begin
               mem[w_add][8*i +: 8] <= w_data[8*i +: 8];
            end
         end
      end
   end

   // Read path: stored word, overlaid with enabled write bytes on a bypass
   // hit, and forced to zero while the clear engine is running
   always_comb begin
      rd_word = mem[r_add];
      if (bypass_hit) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (w_be[i]) begin
               rd_word[8*i +: 8] = w_data[8*i +: 8];
            end
         end
      end
      rd_value = busy ? '0 : rd_word;
   end

`ifdef RAM_RD_REG_EN
   // Registered read output: captures the read value on every edge, so a
   // bypassed write shows up at the same edge that performs it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else begin
         r_data <= rd_value;
      end
   end
`else
   assign r_data = rd_value;
`endif

endmodule

// File: tb/tb_two_port_ram_be.sv
// tb_two_port_ram_be: drives a read-first instance and a bypass instance
// with identical directed vectors. A word-level memory model predicts
// busy and r_data for both every cycle; literal expectations pin the model.
module tb_two_port_ram_be;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        we;
   logic [3:0]  w_be;
   logic [3:0]  w_add;
   logic [31:0] w_data;
   logic [3:0]  r_add;
   logic [31:0] r_data0;
   logic [31:0] r_data1;
   logic        busy0;
   logic        busy1;

   int total = 0;
   int bad   = 0;

   // Model state: word array, number of clear cycles still to run, and the
   // values a registered read port should currently be showing
   logic [31:0] m_mem [16];
   int          m_left;
   logic [31:0] exp_reg0;
   logic [31:0] exp_reg1;

   two_port_ram_be #(
      .A_WIDTH(4), .D_WIDTH(32), .CLR_VALUE(32'h0), .BYPASS(0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .w_be(w_be),
      .w_add(w_add), .w_data(w_data), .r_add(r_add),
      .r_data(r_data0), .busy(busy0)
   );

   two_port_ram_be #(
      .A_WIDTH(4), .D_WIDTH(32), .CLR_VALUE(32'h0), .BYPASS(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .w_be(w_be),
      .w_add(w_add), .w_data(w_data), .r_add(r_add),
      .r_data(r_data1), .busy(busy1)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so a stuck run still ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // What the read port must show right now, from the architectural view
   function automatic logic [31:0] model_read(input bit bypass);
      logic [31:0] w;
      if (m_left != 0) return 32'h0;
      w = m_mem[r_add];
      if (bypass && we && !clr && (r_add == w_add)) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) w[8*i +: 8] = w_data[8*i +: 8];
         end
      end
      return w;
   endfunction

   // Model update on each edge: a clear request (re)starts a 16-cycle
   // sweep, the finished sweep zeroes every word, writes land only when idle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left   = 16;
         exp_reg0 = 32'h0;
         exp_reg1 = 32'h0;
      end else begin
         exp_reg0 = model_read(1'b0);
         exp_reg1 = model_read(1'b1);
         if (clr) begin
            m_left = 16;
         end else if (m_left != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               for (int a = 0; a < 16; a++) m_mem[a] = 32'h0;
            end
         end else if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (w_be[i]) m_mem[w_add][8*i +: 8] = w_data[8*i +: 8];
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      logic [31:0] e0;
      logic [31:0] e1;
`ifdef RAM_RD_REG_EN
      e0 = exp_reg0;
      e1 = exp_reg1;
`else
      e0 = model_read(1'b0);
      e1 = model_read(1'b1);
`endif
      checkOutput("busy0", {31'b0, busy0}, {31'b0, m_left != 0});
      checkOutput("busy1", {31'b0, busy1}, {31'b0, m_left != 0});
      checkOutput("r_data0", r_data0, e0);
      checkOutput("r_data1", r_data1, e1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic c, input logic w,
                                input logic [3:0] be, input logic [3:0] wa,
                                input logic [31:0] wd, input logic [3:0] ra);
      clr    = c;
      we     = w;
      w_be   = be;
      w_add  = wa;
      w_data = wd;
      r_add  = ra;
   endtask

   // Count consecutive cycles with busy high, bounded
   task automatic measure_busy(input string name);
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy0) break;
         n++;
         step();
      end
      checkOutput(name, n, 16);
   endtask

   task automatic read_check(input logic [3:0] a, input logic [31:0] exp0,
                             input logic [31:0] exp1);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, a);
`ifdef RAM_RD_REG_EN
      step();
`endif
      @(negedge clk);
      checkOutput("lit_read0", r_data0, exp0);
      checkOutput("lit_read1", r_data1, exp1);
      step();
   endtask

   task automatic write_word(input logic [3:0] be, input logic [3:0] a,
                             input logic [31:0] d);
      applyStimulus(1'b0, 1'b1, be, a, d, 4'h0);
      step();
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 4'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 4'h0);
      repeat (3) step();

      // Reset release: 16 busy cycles, then every word reads zero
      rst_n = 1'b1;
      measure_busy("t1_busy_len");
      for (int a = 0; a < 16; a++) read_check(4'(a), 32'h0, 32'h0);

      // Byte-enable merging and the all-disabled no-op write
      write_word(4'hF, 4'd3, 32'hAABBCCDD);
      write_word(4'b0101, 4'd3, 32'h11223344);
      read_check(4'd3, 32'hAA22CC44, 32'hAA22CC44);
      write_word(4'h0, 4'd3, 32'hFFFFFFFF);
      read_check(4'd3, 32'hAA22CC44, 32'hAA22CC44);

      // Same-address read during write: read-first versus bypass
      applyStimulus(1'b0, 1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 4'd5);
`ifdef RAM_RD_REG_EN
      step();
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 4'd5);
      @(negedge clk);
      checkOutput("t3_rdfirst", r_data0, 32'h00000000);
      checkOutput("t3_bypass", r_data1, 32'hDEADBEEF);
      step();
`else
      @(negedge clk);
      checkOutput("t3_rdfirst", r_data0, 32'h00000000);
      checkOutput("t3_bypass", r_data1, 32'hDEADBEEF);
      step();
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 4'd5);
`endif
      read_check(4'd5, 32'hDEADBEEF, 32'hDEADBEEF);

      // Clear beats a simultaneous write
      write_word(4'hF, 4'd9, 32'h12345678);
      read_check(4'd9, 32'h12345678, 32'h12345678);
      applyStimulus(1'b1, 1'b1, 4'hF, 4'd9, 32'hFFFFFFFF, 4'd9);
      step();
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 4'd9);
      measure_busy("t4_busy_len");
      read_check(4'd9, 32'h0, 32'h0);

      // Reset in the middle of a sweep restarts it in full
      write_word(4'hF, 4'd12, 32'h55AA55AA);
      read_check(4'd12, 32'h55AA55AA, 32'h55AA55AA);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (7) step();
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 4'd12);
      repeat (3) step();
      @(negedge clk);
      checkOutput("t5_busy_in_rst", {31'b0, busy0}, 32'h1);
      checkOutput("t5_rdata_in_rst", r_data0, 32'h0);
      step();
      rst_n = 1'b1;
      measure_busy("t5_busy_len");
      read_check(4'd12, 32'h0, 32'h0);

      // Writes presented during the sweep are discarded
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 4'd15);
      step();
      applyStimulus(1'b0, 1'b1, 4'hF, 4'd15, 32'h0BADF00D, 4'd15);
      measure_busy("t6_busy_len");
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 4'd15);
      read_check(4'd15, 32'h0, 32'h0);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
